mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 74 +++++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus types for the core-to-memory arbiter: core-side ibus/dbus, memory-side
// request/response, and the arbiter state encoding.
package mem_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } mem_req_t;

    typedef struct packed {
        logic        ready;
        logic [63:0] data;
    } mem_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IBUSY = 2'b01,
        DBUSY = 2'b10
    } arb_state_t;

    localparam logic [2:0] IFETCH_SIZE = 3'b010;
    localparam logic [3:0] DCNT_SAT    = 4'hF;

    // Instruction fetches are 32-bit: address bit 2 picks the half of the 64-bit beat.
    function automatic logic [31:0] fetch_word(input logic [63:0] beat, input logic hi);
        logic [31:0] w;
        if (hi) begin
            w = beat[63:32];
        end else begin
            w = beat[31:0];
        end
        return w;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        logic [3:0] r;
        if (v == DCNT_SAT) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-master, single-outstanding arbiter: serialises core ibus/dbus onto one memory bus,
// dbus first, with a bounded dbus burst so instruction fetch always progresses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DBURST = 4
)(
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output mem_req_t   mreq,
    input  mem_resp_t  mresp
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_IBUSY = IBUSY;
    localparam logic [1:0] ST_DBUSY = DBUSY;
    localparam logic [3:0] MAX_D    = MAX_DBURST[3:0];

    logic [1:0] state_r;
    logic [1:0] next_state_s;
    logic [3:0] dcnt_r;
    logic [3:0] next_dcnt_s;
    mem_req_t   req_r;
    mem_req_t   next_req_s;

    // Grant decision in IDLE and completion detection in the busy states.
    always_comb begin
        next_state_s = state_r;
        next_dcnt_s  = dcnt_r;
        next_req_s   = req_r;
        case (state_r)
            ST_IDLE: begin
                if (dreq.valid && (!ireq.valid || (dcnt_r < MAX_D))) begin
                    next_state_s      = ST_DBUSY;
                    next_req_s.valid  = 1'b1;
                    next_req_s.write  = |dreq.strobe;
                    next_req_s.addr   = dreq.addr;
                    next_req_s.size   = dreq.size;
                    next_req_s.strobe = dreq.strobe;
                    next_req_s.data   = dreq.data;
                    if (ireq.valid) begin
                        next_dcnt_s = sat_inc(dcnt_r);
                    end else begin
                        next_dcnt_s = 4'd0;
                    end
                end else if (ireq.valid) begin
                    next_state_s      = ST_IBUSY;
                    next_dcnt_s       = 4'd0;
                    next_req_s.valid  = 1'b1;
                    next_req_s.write  = 1'b0;
                    next_req_s.addr   = ireq.addr;
                    next_req_s.size   = IFETCH_SIZE;
                    next_req_s.strobe = 8'h00;
                    next_req_s.data   = 64'd0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_IBUSY, ST_DBUSY: begin
                // The request register is frozen until memory reports done.
                if (mresp.ready) begin
                    next_state_s     = ST_IDLE;
                    next_req_s.valid = 1'b0;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_dcnt_s  = 4'd0;
                next_req_s   = '0;
            end
        endcase
    end

    // FSM, burst counter and memory request register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            dcnt_r  <= 4'd0;
            req_r   <= '0;
        end else begin
            state_r <= next_state_s;
            dcnt_r  <= next_dcnt_s;
            req_r   <= next_req_s;
        end
    end

    assign mreq = req_r;

    // Completion pulse goes straight from mresp.ready to the granted side.
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (mresp.ready && (state_r == ST_IBUSY)) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = fetch_word(mresp.data, req_r.addr[2]);
        end else if (mresp.ready && (state_r == ST_DBUSY)) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = mresp.data;
        end else begin
            iresp = '0;
            dresp = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a transaction-level reference model
// and a bench-side memory that chooses latency and return data per transaction.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAXD = 4;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mem_req_t   mreq;
    mem_resp_t  mresp;

    mem_arbiter #(.MAX_DBURST(MAXD)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .mreq  (mreq),
        .mresp (mresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } resp_t;

    resp_t exp_q[$];
    bit    obs_q[$];
    int    tests = 0;
    int    fails = 0;
    int    exp_pulses = 0;
    int    seen_pulses = 0;

    // reference model: one outstanding transaction, consecutive-data-grant tally
    bit          m_busy = 1'b0;
    bit          m_is_d = 1'b0;
    bit          m_completing = 1'b0;
    int          m_dburst = 0;
    int          m_wait = 0;
    logic [63:0] m_data;
    mem_req_t    m_req;

    int          force_lat = -1;
    logic [63:0] force_data;
    bit          force_data_en = 1'b0;
    bit          force_idle_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic ibus_req_t mk_i(input bit v, input logic [63:0] a);
        ibus_req_t r;
        r.valid = v;
        r.addr  = a;
        return r;
    endfunction

    function automatic dbus_req_t mk_d(input bit v, input logic [63:0] a, input logic [2:0] sz,
                                       input logic [7:0] st, input logic [63:0] d);
        dbus_req_t r;
        r.valid  = v;
        r.addr   = a;
        r.size   = sz;
        r.strobe = st;
        r.data   = d;
        return r;
    endfunction

    task automatic start(input bit is_d);
        resp_t r;
        m_busy = 1'b1;
        m_is_d = is_d;
        m_wait = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
        m_data = force_data_en ? force_data : {$urandom, $urandom};
        force_lat     = -1;
        force_data_en = 1'b0;
        m_req.valid = 1'b1;
        r.is_d = is_d;
        if (is_d) begin
            m_req.write  = (dreq.strobe != 8'h00);
            m_req.addr   = dreq.addr;
            m_req.size   = dreq.size;
            m_req.strobe = dreq.strobe;
            m_req.data   = dreq.data;
            r.data       = m_data;
        end else begin
            m_req.write  = 1'b0;
            m_req.addr   = ireq.addr;
            m_req.size   = 3'd2;
            m_req.strobe = 8'h00;
            m_req.data   = 64'd0;
            r.data = ((ireq.addr % 8) >= 4) ? (m_data >> 32) : (m_data % 64'h1_0000_0000);
        end
        exp_q.push_back(r);
    endtask

    task automatic model_edge();
        if (reset) begin
            if (m_busy) begin
                if (mresp.ready) m_busy = 1'b0;
            end else if (dreq.valid && (!ireq.valid || m_dburst < MAXD)) begin
                m_dburst = ireq.valid ? ((m_dburst < 15) ? m_dburst + 1 : 15) : 0;
                start(1'b1);
            end else if (ireq.valid) begin
                m_dburst = 0;
                start(1'b0);
            end
        end
    endtask

    task automatic mem_drive();
        m_completing = 1'b0;
        if (!reset || !m_busy) begin
            mresp.ready = reset && (force_idle_ready || ($urandom_range(0, 5) == 0));
            mresp.data  = {$urandom, $urandom};
            force_idle_ready = 1'b0;
        end else if (m_wait == 0) begin
            mresp.ready  = 1'b1;
            mresp.data   = m_data;
            m_completing = 1'b1;
            exp_pulses++;
        end else begin
            mresp.ready = 1'b0;
            mresp.data  = {$urandom, $urandom};
            m_wait--;
        end
    endtask

    task automatic cycle(input ibus_req_t ni, input dbus_req_t nd, input logic nrst);
        @(posedge clk);
        #1;
        model_edge();
        if (!nrst) begin
            if (reset && m_busy) void'(exp_q.pop_back());
            m_busy   = 1'b0;
            m_dburst = 0;
        end
        reset = nrst;
        ireq  = ni;
        dreq  = nd;
        mem_drive();
    endtask

    task automatic idle_wait();
        int k = 0;
        do begin
            cycle(mk_i(1'b0, 64'd0), mk_d(1'b0, 64'd0, 3'd0, 8'h00, 64'd0), 1'b1);
            k++;
        end while (m_busy && k < 100);
        if (m_busy) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", k);
        end
    endtask

    task automatic run_until_obs(input int n, input ibus_req_t ni, input dbus_req_t nd);
        int k = 0;
        while (obs_q.size() < n && k < 300) begin
            cycle(ni, nd, 1'b1);
            k++;
        end
        if (obs_q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: got %0d grants expected %0d", obs_q.size(), n);
        end
    endtask

    // monitor: per-cycle request checks and scoreboard pops on response pulses
    initial begin
        bit    prev_v;
        bit    ip;
        bit    dp;
        resp_t r;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            ip = iresp.addr_ok | iresp.data_ok;
            dp = dresp.addr_ok | dresp.data_ok;
            check("mreq_valid", 64'(mreq.valid), 64'(m_busy));
            if (m_busy) begin
                check("mreq_write", 64'(mreq.write), 64'(m_req.write));
                check("mreq_addr", mreq.addr, m_req.addr);
                check("mreq_size", 64'(mreq.size), 64'(m_req.size));
                check("mreq_strobe", 64'(mreq.strobe), 64'(m_req.strobe));
                if (m_is_d) check("mreq_data", mreq.data, m_req.data);
            end
            if (!reset) begin
                check("rst_iresp", 64'(iresp), 64'd0);
                check("rst_dresp_ok", 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
                check("rst_dresp_data", dresp.data, 64'd0);
            end
            check("dual_pulse", 64'(ip & dp), 64'd0);
            check("pulse_expected", 64'(ip | dp), 64'(m_completing));
            if (ip || dp) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got i=%0d d=%0d expected no pulse", ip, dp);
                end else begin
                    r = exp_q.pop_front();
                    seen_pulses++;
                    check("resp_side", 64'(dp), 64'(r.is_d));
                    if (dp) begin
                        check("d_ok_pair", 64'({dresp.addr_ok, dresp.data_ok}), 64'd3);
                        check("d_data", dresp.data, r.data);
                    end else begin
                        check("i_ok_pair", 64'({iresp.addr_ok, iresp.data_ok}), 64'd3);
                        check("i_data", 64'(iresp.data), r.data);
                    end
                end
            end
            if (mreq.valid && !prev_v) obs_q.push_back(mreq.addr[31]);
            prev_v = mreq.valid;
        end
    end

    initial begin
        bit        starve_exp[6];
        ibus_req_t zi;
        dbus_req_t zd;
        zi = mk_i(1'b0, 64'd0);
        zd = mk_d(1'b0, 64'd0, 3'd0, 8'h00, 64'd0);
        starve_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        reset = 1'b0;
        ireq  = '0;
        dreq  = '0;
        mresp = '0;

        // reset held with both requesters active; dbus must win on release
        for (int i = 0; i < 4; i++)
            cycle(mk_i(1'b1, 64'h200), mk_d(1'b1, 64'h8000_0100, 3'd3, 8'hFF, 64'h55), 1'b0);
        obs_q.delete();
        run_until_obs(1, mk_i(1'b1, 64'h200), mk_d(1'b1, 64'h8000_0100, 3'd3, 8'hFF, 64'h55));
        if (obs_q.size() > 0) check("first_grant_dbus", 64'(obs_q[0]), 64'd1);
        idle_wait();

        // single fetch, upper word; valid drops right after grant
        force_lat     = 2;
        force_data    = 64'h1111_2222_3333_4444;
        force_data_en = 1'b1;
        cycle(mk_i(1'b1, 64'h8000_0004), zd, 1'b1);
        idle_wait();

        // store with a long memory stall
        force_lat = 5;
        cycle(zi, mk_d(1'b1, 64'h8000_0010, 3'd3, 8'h0F, 64'h0000_0000_DEAD_BEEF), 1'b1);
        idle_wait();

        // late ready while idle
        force_idle_ready = 1'b1;
        cycle(zi, zd, 1'b1);
        cycle(zi, zd, 1'b1);

        // reset during a stalled data access
        force_lat = 6;
        cycle(zi, mk_d(1'b1, 64'h8000_0020, 3'd3, 8'hFF, 64'h1234), 1'b1);
        cycle(zi, zd, 1'b1);
        cycle(zi, zd, 1'b1);
        cycle(zi, zd, 1'b0);
        cycle(zi, zd, 1'b0);
        cycle(zi, zd, 1'b1);
        idle_wait();

        // starvation limit: both held high from a clean counter
        cycle(zi, zd, 1'b0);
        cycle(zi, zd, 1'b1);
        obs_q.delete();
        run_until_obs(6, mk_i(1'b1, 64'h1000), mk_d(1'b1, 64'h8000_0000, 3'd3, 8'h00, 64'd0));
        for (int i = 0; i < 6; i++)
            if (obs_q.size() > i) check($sformatf("starve_grant%0d", i), 64'(obs_q[i]), 64'(starve_exp[i]));
        idle_wait();

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(mk_i($urandom_range(0, 99) < 60, {32'd0, $urandom}),
                  mk_d($urandom_range(0, 99) < 60, {$urandom, $urandom}, 3'($urandom_range(0, 3)),
                       ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom}),
                  $urandom_range(0, 199) != 0);
        end
        idle_wait();

        check("pulse_count", 64'(seen_pulses), 64'(exp_pulses));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
